// File: rtl/tile_seq_pkg.sv
// Shared types and helpers for the tile enable sequencer: FSM state encoding,
// lowest-set-bit selection and counter width calculation.
package tile_seq_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } seq_state_t;

  // Widest tile vector lowest_one() handles; callers zero-extend and truncate.
  localparam int MAX_TILES = 32;

  // Bits needed to hold values 0..max_val, never less than 1.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // One-hot of the lowest set bit of vec (all zeros when vec is zero).
  function automatic logic [MAX_TILES-1:0] lowest_one(input logic [MAX_TILES-1:0] vec);
    return vec & (~vec + MAX_TILES'(1));
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: SYNC_STAGES-flop synchroniser followed by a debouncer that only
// accepts a new level after DEBOUNCE_CYC consecutive cycles of disagreement.
module sw_debounce
  import tile_seq_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic q_stable
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   s;

  assign s        = sync_q[SYNC_STAGES-1];
  assign q_stable = stable_q;

  // The counter is held below DEBOUNCE_CYC: the cycle it would reach it is the
  // cycle the new level is accepted and the count restarts from zero.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (s != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], d_raw};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/tile_enable_sequencer.sv
// Debounces the tile slide switches and staggers tile turn-on one tile per
// STAGGER_CYC cycles; turn-off is immediate. Stagger FSM built only with TILE_SEQ_STAGGER_EN.
module tile_enable_sequencer
  import tile_seq_pkg::*;
#(
  parameter int TILE_COUNT   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int STAGGER_CYC  = 200_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TILE_COUNT-1:0] sw_raw,
  output logic [TILE_COUNT-1:0] sw_stable,
  output logic [TILE_COUNT-1:0] tile_en,
  output logic                  busy
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || STAGGER_CYC < 1 || TILE_COUNT > MAX_TILES)
  begin : g_bad_param
    $error("tile_enable_sequencer: illegal parameter value");
  end

  logic [TILE_COUNT-1:0] sw_stable_w;
  logic [TILE_COUNT-1:0] tile_q;

  for (genvar gi = 0; gi < TILE_COUNT; gi++) begin : g_db
    sw_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .d_raw   (sw_raw[gi]),
      .q_stable(sw_stable_w[gi])
    );
  end

  assign sw_stable = sw_stable_w;
  assign tile_en   = tile_q;

`ifdef TILE_SEQ_STAGGER_EN

  localparam int TW = cnt_width(STAGGER_CYC - 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(STAGGER_CYC - 1);

  seq_state_t            state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [TILE_COUNT-1:0] tile_d;
  logic                  busy_q, busy_d;
  logic [TILE_COUNT-1:0] tile_masked;
  logic [TILE_COUNT-1:0] pend;
  logic [TILE_COUNT-1:0] lo_pend;

  // Turn-off masking is applied before pend is formed, so a bit dropping this
  // cycle is never counted as still enabled when choosing the next one to raise.
  always_comb begin
    tile_masked = tile_q & sw_stable_w;
    pend        = sw_stable_w & ~tile_masked;
    lo_pend     = TILE_COUNT'(lowest_one(MAX_TILES'(pend)));
    state_d     = state_q;
    timer_d     = timer_q;
    tile_d      = tile_masked;
    case (state_q)
      IDLE: begin
        if (|pend) begin
          tile_d  = tile_masked | lo_pend;
          timer_d = TIMER_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // The expiry cycle doubles as the IDLE pass, so back-to-back rises land
        // exactly STAGGER_CYC cycles apart rather than one cycle later.
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (|pend) begin
          tile_d  = tile_masked | lo_pend;
          timer_d = TIMER_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SETTLE) | (|(sw_stable_w & ~tile_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      tile_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tile_q  <= tile_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

`else

  // Without staggering every debounced switch drives its tile one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_q <= '0;
    end else begin
      tile_q <= sw_stable_w;
    end
  end

  assign busy = 1'b0;

`endif

endmodule
